iter_div: RTL
=============

Name: iter_div

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
- Sits beside the EX-stage ALU. EX launches it when an op_div/op_divu instruction issues and stalls until the result returns.
- The quotient/remainder pair is consumed by the HI/LO write logic: LO <= s, HI <= r.
- Supports flush on exception or eret, so a cancelled divide never writes HI/LO.

Parameters:
- WIDTH, 32, operand and result width in bits. Latency scales with WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- div_valid  input  1  EX requests a divide this cycle.
- div_ready  output  1  divider can accept a request; high only in IDLE.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- x  input  WIDTH  dividend; sampled at accept.
- y  input  WIDTH  divisor; sampled at accept.
- flush  input  1  cancel any operation in flight.
- res_valid  output  1  s/r valid; held until consumed.
- res_ready  input  1  consumer takes the result.
- s  output  WIDTH  quotient.
- r  output  WIDTH  remainder.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset forces state IDLE, res_valid=0, s=0, r=0, counter=0. div_ready=1 in the first cycle after reset.
- States:
  - IDLE -> BUSY on accept (div_valid & div_ready & ~flush).
  - BUSY -> DONE after WIDTH iterations.
  - DONE -> IDLE on res_valid & res_ready.
  - Any state -> IDLE on flush.
- Accept (cycle 0):
  - Latch |x|, |y|, sign_q = div_signed & (x[W-1]^y[W-1]), sign_r = div_signed & x[W-1], and a y_zero flag.
  - Absolute values are computed only when div_signed=1.
  - |0x80000000| = 0x80000000 unsigned; no extra width needed beyond a WIDTH+1 partial remainder.
- Iteration (BUSY, cycles 1..WIDTH):
  - Shift {rem, quo} left by 1, trial-subtract |y| from rem.
  - If no borrow, keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0.
  - Counter counts 0..WIDTH-1.
- Finish (last BUSY cycle):
  - Register s = sign_q ? -quo : quo and r = sign_r ? -rem : rem.
  - res_valid rises in cycle WIDTH+1 after accept (33 for WIDTH=32).
- Divide by zero: s = all ones, r = x as latched raw (no sign fix). Same latency, no exception raised; MIPS leaves the result UNPREDICTABLE, and we fix it for determinism.
- Overflow (signed 0x80000000 / -1): s = 0x80000000, r = 0, via natural wrap. No special case.
- Back-pressure: in DONE, s/r/res_valid stay stable while res_ready=0.
- Handshake:
  - div_ready = (state==IDLE), combinational from state only.
  - No new accept in the same cycle as result consumption; the next request is accepted the following cycle.
- Flush:
  - Takes priority over every other event.
  - Next cycle: state IDLE, res_valid=0, counter cleared. s/r may keep stale values but res_valid=0.
  - flush together with div_valid in IDLE: request not accepted.
- div_signed, x and y are ignored outside the accept cycle.
- Reset mid-operation behaves like flush, and additionally clears s and r to 0.

Decomposition:
- Shared package div_pkg:
  - State encoding typedef {IDLE, BUSY, DONE}.
  - DIV_LAT = WIDTH+1 constant for EX stall accounting.
  - DIV_ZERO_Q = all-ones constant.
- Optional leaf sub-module div_sign_fix: combinational absolute value / conditional negate, used at input and output.
- The rest is one FSM + datapath file.

Test Plan:
- DIVU x=7, y=2, accept at cycle 0 -> res_valid rises at cycle 33 with s=0x00000003, r=0x00000001; div_ready=0 during cycles 1..33.
- DIV x=0xFFFFFFF9 (-7), y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF; DIV x=7, y=0xFFFFFFFE -> s=0xFFFFFFFD, r=0x00000001.
- DIV x=0x80000000, y=0xFFFFFFFF -> s=0x80000000, r=0; DIVU same operands -> s=0, r=0x80000000.
- DIVU x=0x1234, y=0 -> s=0xFFFFFFFF, r=0x00001234 at cycle 33.
- Accept DIVU 100/7, flush at cycle 10 -> res_valid never rises, div_ready=1 at cycle 11. New DIVU 100/7 accepted at cycle 11 -> s=14, r=2 at cycle 44.
- Result ready with res_ready=0 for 5 cycles -> s/r/res_valid unchanged each cycle. res_ready=1 -> res_valid=0 and div_ready=1 next cycle; div_valid held high is accepted only then.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS divider.
// Latency: DIV_LAT cycles from accept to res_valid at the default width.
// Backpressure: n/a (package only).
package div_pkg;

  // Default operand width and the matching EX stall budget
  localparam int DIV_WIDTH = 32;
  localparam int DIV_LAT   = DIV_WIDTH + 1;

  // Quotient returned for a zero divisor (fixed for determinism)
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; yields |v| at the input side and restores sign at the output side.
// Latency: combinational.
// Backpressure: none.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // Negating the most negative value wraps to itself, which reads as the correct unsigned magnitude
  assign o_val = i_neg ? (WIDTH'(0) - i_val) : i_val;

endmodule

// File: rtl/iter_div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; quotient to LO (s), remainder to HI (r).
// Latency: res_valid rises WIDTH+1 cycles after accept; one quotient bit per BUSY cycle.
// Backpressure: result held stable in DONE until res_ready; div_ready only in IDLE; flush cancels anything in flight.
module iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_absy;
  logic [WIDTH-1:0] r_xraw;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_yzero;

  logic             w_neg_x;
  logic             w_neg_y;
  logic [WIDTH-1:0] w_absx;
  logic [WIDTH-1:0] w_absy;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_s_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_last;

  assign div_ready = (r_state == IDLE);

  // Magnitudes are only taken for signed ops; DIVU passes operands straight through
  assign w_neg_x = div_signed & x[WIDTH-1];
  assign w_neg_y = div_signed & y[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_x (.i_neg(w_neg_x), .i_val(x), .o_val(w_absx));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_y (.i_neg(w_neg_y), .i_val(y), .o_val(w_absy));

  // One restoring step: the shifted partial remainder is WIDTH+1 bits, and when it is >= |y|
  // the true difference is below 2^WIDTH, so the low WIDTH bits of the subtraction are exact
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_absy});
  assign w_diff    = w_shift[WIDTH-1:0] - r_absy;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Sign restoration works on the final step's output so the result registers on the last BUSY edge
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_neg(r_sign_q), .i_val(w_quo_nxt), .o_val(w_s_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.i_neg(r_sign_r), .i_val(w_rem_nxt), .o_val(w_r_fix));

  // Control FSM and datapath; reset and flush outrank every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      s         <= '0;
      r         <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_absy    <= '0;
      r_xraw    <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_yzero   <= 1'b0;
    end else if (flush) begin
      // s/r keep stale contents; res_valid=0 marks them unusable
      r_state   <= IDLE;
      r_cnt     <= '0;
      res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_valid) begin
            r_state  <= BUSY;
            r_cnt    <= '0;
            r_quo    <= w_absx;
            r_rem    <= '0;
            r_absy   <= w_absy;
            r_xraw   <= x;
            r_sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            r_sign_r <= w_neg_x;
            r_yzero  <= (y == '0);
          end
        end
        BUSY: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state   <= DONE;
            r_cnt     <= '0;
            res_valid <= 1'b1;
            // Zero divisor: all-ones quotient and the raw dividend, no sign fix
            s         <= r_yzero ? '1 : w_s_fix;
            r         <= r_yzero ? r_xraw : w_r_fix;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state   <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
